sata_txframe: RTL
=================

# sata_txframe

Transmit frame packer between the transmit data FIFO and the link-layer transmitter. It pops 33-bit entries `{last, dword}` from the upstream synchronous FIFO, which uses asynchronous read (data valid whenever not empty), and presents them one dword per beat on a registered valid/ready stream. It appends the SATA CRC dword after each frame's final data dword and enforces a maximum frame length.

## Interface
- `MAX_WORDS`, default 2049: maximum data dwords per frame (FIS header plus 2048 payload dwords); range 2..65535.
- `LGMAX`, default 12: width of the word counter; must satisfy `2^LGMAX > MAX_WORDS`.

Ports (clock and reset first):
- `i_clk` in 1: single clock.
- `i_reset_n` in 1: asynchronous, active-low reset.
- `i_fifo_empty` in 1: upstream FIFO empty flag.
- `i_fifo_data` in 33: bit 32 = last, bits 31:0 = dword; valid when `!i_fifo_empty`.
- `o_fifo_rd` out 1: pop strobe, combinational; never asserted while `i_fifo_empty`.
- `o_valid` out 1: output beat valid.
- `i_ready` in 1: downstream accepts the beat when `o_valid && i_ready`.
- `o_data` out 32: output dword.
- `o_last` out 1: final beat of the frame (the CRC beat when CRC is enabled).
- `o_busy` out 1: high while in any state other than IDLE.
- `o_overflow` out 1: one-cycle pulse when a frame exceeds `MAX_WORDS`.

## Operation
- States are IDLE, DATA, CRC and DROP. The output holding register (`o_valid`, `o_data`, `o_last`) is free when `!o_valid || i_ready`.
- **IDLE and DATA.** `o_fifo_rd = !i_fifo_empty && free`.
  - Each pop loads `o_data <= dword` and `o_valid <= 1`.
  - The CRC register updates with the dword.
  - The word count increments.
- **IDLE to DATA.** Taken on the first pop of a frame.
  - Before this pop, the CRC register is set to 0x52325032 and the count is set to 0.
- **Frame end.** A popped entry with last=1, or a pop that brings the count to `MAX_WORDS`, moves to CRC.
  - If `MAX_WORDS` is reached with last=0, `o_overflow` pulses in that same cycle and the next state is DROP instead of CRC. In DROP, the CRC beat is emitted first, then the remainder of the frame is discarded.
- **CRC state.** `o_fifo_rd = 0`. When free, load `o_data <= crc`, `o_last <= 1` and `o_valid <= 1`.
  - Next state is IDLE, or DROP if overflow is pending.
- **DROP state.** `o_fifo_rd = !i_fifo_empty`, and popped data is discarded.
  - A popped entry with last=1 returns the block to IDLE.
- **CRC arithmetic.** Polynomial 0x04C11DB7, non-reflected, MSB-first, 32 bits per dword, no final XOR. The update is combinational across all 32 bits within one cycle.
- **Output register.** When free and nothing is loaded, `o_valid <= 0`. `o_last <= 0` on every data beat except in the no-CRC build.
- **Reset values.** `o_valid=0`, `o_data=0`, `o_last=0`, `o_busy=0`, `o_overflow=0`, state IDLE, count 0, CRC 0x52325032.
- **Reset mid-frame.** Any partial frame is abandoned; nothing is re-emitted.

## Timing
- Latency from pop to `o_valid` is one cycle. Throughput is one dword per cycle with `i_ready` held high.
- One bubble-free CRC beat follows the last data beat, so an N-dword frame occupies N+1 output beats.
- A new frame's first pop may occur in the same cycle the CRC beat of the previous frame is accepted. The CRC state itself does not pop, so there is one idle pop cycle per frame.
- `o_data`, `o_last` and `o_valid` are held stable while `o_valid && !i_ready`.
- `o_fifo_rd` depends combinationally on `i_ready`, `i_fifo_empty` and state; there is no combinational path from `i_fifo_data`.
- FIFO empty between dwords of a frame inserts output bubbles; the frame is not terminated.

## Configuration
- `SATA_TXFRAME_CRC_EN` defined:
  - The CRC state and CRC register are present.
  - `o_last` is set on the CRC beat only.
- `SATA_TXFRAME_CRC_EN` undefined:
  - No CRC logic is present, and DATA goes directly to IDLE or DROP.
  - `o_last` is set on the final data beat: popped last=1, or the `MAX_WORDS`th dword.
  - N-dword frames produce N beats.

## Test plan
- **Reset.** Hold `i_reset_n=0` with the FIFO non-empty. All outputs must stay at reset values and `o_fifo_rd=0`. Release reset: the first pop must occur the same cycle.
- **Single frame.** Push `{0,0x00308027}`, `{1,0x12345678}` with `i_ready=1`. The output must be exactly 3 beats: 0x00308027, 0x12345678, then the CRC matching the bench reference model (init 0x52325032). `o_last` must be high only on beat 3.
- **Backpressure.** Push a 5-dword frame and toggle `i_ready` randomly. `o_data` must be stable while stalled, with no lost or duplicated beat, and the CRC must match the model.
- **Back-to-back frames.** Push three 1-dword frames continuously. The output must be 6 beats, each CRC must be computed from a fresh init, and `o_busy` must drop only after the final CRC beat is accepted.
- **Overflow.** With `MAX_WORDS=4`, push a 7-dword frame followed by a 1-dword frame.
  - Required: 4 data beats, then the CRC beat with `o_last`, and `o_overflow` pulsing once on the 4th pop.
  - Dwords 5–7 must be dropped.
  - The next frame must emit normally.
- **No-CRC build.** With the macro undefined, push a 3-dword frame. The output must be 3 beats with `o_last` on the third beat.

Source files
------------

// File: rtl/sata_txframe.sv
// SATA transmit frame packer: pops {last, dword} from the TX FIFO, emits one dword per beat
// and enforces MAX_WORDS. Optional CRC dword append is enabled by `define SATA_TXFRAME_CRC_EN.
module sata_txframe #(
    parameter int MAX_WORDS = 2049,
    parameter int LGMAX     = 12
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_fifo_empty,
    input  logic [32:0] i_fifo_data,
    output logic        o_fifo_rd,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_data,
    output logic        o_last,
    output logic        o_busy,
    output logic        o_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [LGMAX-1:0] MAX_CNT = LGMAX'(MAX_WORDS);

`ifdef SATA_TXFRAME_CRC_EN
    localparam logic [31:0] CRC_INIT = 32'h5232_5032;
    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;

    function automatic logic [31:0] crc32_dword(input logic [31:0] crc, input logic [31:0] d);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 31; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0000_0000);
        end
        return c;
    endfunction

    logic [31:0] crc_q, crc_d;
    logic        pend_q, pend_d;
`endif

    state_t             state_q, state_d;
    logic [LGMAX-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [31:0]        data_q, data_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               free_s;
    logic               pop_s;
    logic               ovf_s;
    logic               last_in_s;
    logic [31:0]        word_s;
    logic [LGMAX-1:0]   cnt_inc_s;
    logic               end_s;

    assign free_s    = !valid_q || i_ready;
    assign last_in_s = i_fifo_data[32];
    assign word_s    = i_fifo_data[31:0];
    assign cnt_inc_s = ((state_q == S_IDLE) ? '0 : cnt_q) + LGMAX'(1);
    assign end_s     = last_in_s || (cnt_inc_s == MAX_CNT);

    // Next-state, pop strobe and output-holding-register load logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        last_d  = last_q;
        pop_s   = 1'b0;
        ovf_s   = 1'b0;
`ifdef SATA_TXFRAME_CRC_EN
        crc_d   = crc_q;
        pend_d  = pend_q;
`endif
        if (free_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE, S_DATA: begin
                pop_s = i_reset_n && !i_fifo_empty && free_s;
                if (pop_s) begin
                    valid_d = 1'b1;
                    data_d  = word_s;
                    cnt_d   = cnt_inc_s;
                    ovf_s   = !last_in_s && (cnt_inc_s == MAX_CNT);
`ifdef SATA_TXFRAME_CRC_EN
                    // A fresh frame starts from the seed, not from the last frame's residue
                    crc_d  = crc32_dword((state_q == S_IDLE) ? CRC_INIT : crc_q, word_s);
                    last_d = 1'b0;
                    if (end_s) begin
                        state_d = S_CRC;
                        pend_d  = ovf_s;
                    end else begin
                        state_d = S_DATA;
                    end
`else
                    last_d = end_s;
                    if (end_s) begin
                        state_d = ovf_s ? S_DROP : S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
`endif
                end else begin
                    state_d = state_q;
                end
            end
`ifdef SATA_TXFRAME_CRC_EN
            S_CRC: begin
                if (free_s) begin
                    valid_d = 1'b1;
                    data_d  = crc_q;
                    last_d  = 1'b1;
                    state_d = pend_q ? S_DROP : S_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    state_d = S_CRC;
                end
            end
`endif
            S_DROP: begin
                pop_s = i_reset_n && !i_fifo_empty;
                if (pop_s && last_in_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DROP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE) || valid_d;
    end

    // State, counter and output register update
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 32'h0000_0000;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SATA_TXFRAME_CRC_EN
            crc_q   <= CRC_INIT;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
`ifdef SATA_TXFRAME_CRC_EN
            crc_q   <= crc_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign o_fifo_rd  = pop_s;
    assign o_overflow = ovf_s;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_last     = last_q;
    assign o_busy     = busy_q;

endmodule
